// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetch/exec/wait-mem control of the control-store
// address, with condition-code latch and opcode decode dispatch.
module microcode_sequencer #(
   parameter int DATAWIDTH_JUMPADDRESS = 11,
   parameter int DATAWIDTH_CONDITION   = 3,
   parameter int DATAWIDTH_IR          = 32
) (
   input  logic                             MICROCODE_SEQUENCER_CLOCK_50,
   input  logic                             MICROCODE_SEQUENCER_ResetInHigh_In,
   input  logic [DATAWIDTH_CONDITION-1:0]   MICROCODE_SEQUENCER_Condition_InBus,
   input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICROCODE_SEQUENCER_JumpAddress_InBus,
   input  logic [DATAWIDTH_IR-1:0]          MICROCODE_SEQUENCER_IR_InBus,
   input  logic                             MICROCODE_SEQUENCER_RD_In,
   input  logic                             MICROCODE_SEQUENCER_WRMain_In,
   input  logic                             MICROCODE_SEQUENCER_MemAck_In,
   input  logic                             MICROCODE_SEQUENCER_FlagsLoad_In,
   input  logic [3:0]                       MICROCODE_SEQUENCER_NZVC_InBus,
   output logic [DATAWIDTH_JUMPADDRESS-1:0] MICROCODE_SEQUENCER_CSAddress_OutBus,
   output logic                             MICROCODE_SEQUENCER_ExecEnable_Out,
   output logic [3:0]                       MICROCODE_SEQUENCER_PSR_OutBus
);

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      EXEC     = 2'd1,
      WAIT_MEM = 2'd2
   } state_t;

   state_t                           state;
   logic [DATAWIDTH_JUMPADDRESS-1:0] csAddress;
   logic                             execEnable;
   logic [3:0]                       psr;
   logic [DATAWIDTH_JUMPADDRESS-1:0] incAddress;
   logic [DATAWIDTH_JUMPADDRESS-1:0] decodeAddress;
   logic [DATAWIDTH_JUMPADDRESS-1:0] jumpAddress;
   logic [DATAWIDTH_JUMPADDRESS-1:0] nextAddress;
   logic                             memRequest;
   logic                             unusedIrBits;

   assign jumpAddress   = MICROCODE_SEQUENCER_JumpAddress_InBus;
   assign incAddress    = csAddress + DATAWIDTH_JUMPADDRESS'(1);
   assign decodeAddress = DATAWIDTH_JUMPADDRESS'({1'b1,
                             MICROCODE_SEQUENCER_IR_InBus[31:30],
                             MICROCODE_SEQUENCER_IR_InBus[24:19],
                             2'b00});
   assign memRequest    = MICROCODE_SEQUENCER_RD_In |
                          MICROCODE_SEQUENCER_WRMain_In;
   assign unusedIrBits  = ^{MICROCODE_SEQUENCER_IR_InBus[29:25],
                            MICROCODE_SEQUENCER_IR_InBus[18:14],
                            MICROCODE_SEQUENCER_IR_InBus[12:0]};

   // Next-address select; tests use the PSR value before this edge's update
   always_comb begin
      nextAddress = incAddress;
      case (MICROCODE_SEQUENCER_Condition_InBus)
         3'd1:    nextAddress = psr[3] ? jumpAddress : incAddress;
         3'd2:    nextAddress = psr[2] ? jumpAddress : incAddress;
         3'd3:    nextAddress = psr[1] ? jumpAddress : incAddress;
         3'd4:    nextAddress = psr[0] ? jumpAddress : incAddress;
         3'd5:    nextAddress = MICROCODE_SEQUENCER_IR_InBus[13] ?
                                jumpAddress : incAddress;
         3'd6:    nextAddress = jumpAddress;
         3'd7:    nextAddress = decodeAddress;
         default: nextAddress = incAddress;
      endcase
   end

   // Sequencer FSM with registered address, exec strobe and PSR
   always_ff @(posedge MICROCODE_SEQUENCER_CLOCK_50) begin
      if (MICROCODE_SEQUENCER_ResetInHigh_In) begin
         state      <= FETCH;
         csAddress  <= '0;
         execEnable <= 1'b0;
         psr        <= 4'b0000;
      end else begin
         case (state)
            FETCH: begin
               state      <= EXEC;
               execEnable <= 1'b1;
            end
            EXEC: begin
               execEnable <= 1'b0;
               if (memRequest && !MICROCODE_SEQUENCER_MemAck_In) begin
                  state <= WAIT_MEM;
               end else begin
                  state     <= FETCH;
                  csAddress <= nextAddress;
                  if (MICROCODE_SEQUENCER_FlagsLoad_In)
                     psr <= MICROCODE_SEQUENCER_NZVC_InBus;
               end
            end
            WAIT_MEM: begin
               execEnable <= 1'b0;
               if (MICROCODE_SEQUENCER_MemAck_In) begin
                  state     <= FETCH;
                  csAddress <= nextAddress;
                  if (MICROCODE_SEQUENCER_FlagsLoad_In)
                     psr <= MICROCODE_SEQUENCER_NZVC_InBus;
               end
            end
            default: begin
               state      <= FETCH;
               execEnable <= 1'b0;
            end
         endcase
      end
   end

   assign MICROCODE_SEQUENCER_CSAddress_OutBus = csAddress;
   assign MICROCODE_SEQUENCER_ExecEnable_Out   = execEnable;
   assign MICROCODE_SEQUENCER_PSR_OutBus       = psr;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed scoreboard bench for microcode_sequencer.
module tb_microcode_sequencer;

   typedef struct {
      logic        rst;
      logic [2:0]  cond;
      logic [10:0] jump;
      logic [31:0] ir;
      logic        rd;
      logic        wr;
      logic        ack;
      logic        fl;
      logic [3:0]  nzvc;
   } stim_t;

   typedef struct {
      logic [10:0] cs;
      logic        ee;
      logic [3:0]  psr;
   } exp_t;

   localparam logic [31:0] IR_ADDCC  = 32'h8080_0000;
   localparam logic [31:0] IR_BRANCH = 32'h0080_0000;
   localparam logic [31:0] IR_BIT13  = 32'h0000_2000;

   logic        clk;
   logic        rst;
   logic [2:0]  cond;
   logic [10:0] jump;
   logic [31:0] ir;
   logic        rd;
   logic        wr;
   logic        ack;
   logic        fl;
   logic [3:0]  nzvc;
   logic [10:0] cs;
   logic        ee;
   logic [3:0]  psr;

   int   checks;
   int   fails;
   exp_t sb[$];

   microcode_sequencer dut (
      .MICROCODE_SEQUENCER_CLOCK_50         (clk),
      .MICROCODE_SEQUENCER_ResetInHigh_In   (rst),
      .MICROCODE_SEQUENCER_Condition_InBus  (cond),
      .MICROCODE_SEQUENCER_JumpAddress_InBus(jump),
      .MICROCODE_SEQUENCER_IR_InBus         (ir),
      .MICROCODE_SEQUENCER_RD_In            (rd),
      .MICROCODE_SEQUENCER_WRMain_In        (wr),
      .MICROCODE_SEQUENCER_MemAck_In        (ack),
      .MICROCODE_SEQUENCER_FlagsLoad_In     (fl),
      .MICROCODE_SEQUENCER_NZVC_InBus       (nzvc),
      .MICROCODE_SEQUENCER_CSAddress_OutBus (cs),
      .MICROCODE_SEQUENCER_ExecEnable_Out   (ee),
      .MICROCODE_SEQUENCER_PSR_OutBus       (psr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t st(input logic r, input logic [2:0] c,
                                input logic [10:0] j, input logic [31:0] i,
                                input logic rdv, input logic wrv,
                                input logic a, input logic f,
                                input logic [3:0] n);
      stim_t s;
      s.rst = r; s.cond = c; s.jump = j; s.ir = i;
      s.rd = rdv; s.wr = wrv; s.ack = a; s.fl = f; s.nzvc = n;
      return s;
   endfunction

   function automatic stim_t idle();
      return st(1'b0, 3'd0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
   endfunction

   function automatic exp_t ex(input logic [10:0] c, input logic e,
                               input logic [3:0] p);
      exp_t x;
      x.cs = c; x.ee = e; x.psr = p;
      return x;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst; cond = s.cond; jump = s.jump; ir = s.ir;
      rd = s.rd; wr = s.wr; ack = s.ack; fl = s.fl; nzvc = s.nzvc;
   endtask

   task automatic test_reset();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      sq.push_back(st(1,0,0,0,0,0,0,0,0)); eq.push_back(ex(0,0,0));
      sq.push_back(st(1,0,0,0,0,0,0,0,0)); eq.push_back(ex(0,0,0));
      sq.push_back(idle());                eq.push_back(ex(0,1,0));
      sq.push_back(idle());                eq.push_back(ex(1,0,0));
      sq.push_back(idle());                eq.push_back(ex(1,1,0));
      sq.push_back(idle());                eq.push_back(ex(2,0,0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb.push_back(eq[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (cs !== e.cs || ee !== e.ee || psr !== e.psr) begin
            fails++;
            $display("FAIL reset step %0d: got cs=%0d ee=%b psr=%b, want cs=%0d ee=%b psr=%b",
                     i, cs, ee, psr, e.cs, e.ee, e.psr);
         end
      end
   endtask

   task automatic test_decode();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      sq.push_back(st(1,0,0,0,0,0,0,0,0));         eq.push_back(ex(0,0,0));
      sq.push_back(idle());                        eq.push_back(ex(0,1,0));
      sq.push_back(idle());                        eq.push_back(ex(1,0,0));
      sq.push_back(idle());                        eq.push_back(ex(1,1,0));
      sq.push_back(st(0,7,5,IR_ADDCC,0,0,0,0,0));  eq.push_back(ex(1600,0,0));
      sq.push_back(idle());                        eq.push_back(ex(1600,1,0));
      sq.push_back(st(0,7,9,IR_BRANCH,0,0,0,0,0)); eq.push_back(ex(1088,0,0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb.push_back(eq[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (cs !== e.cs || ee !== e.ee || psr !== e.psr) begin
            fails++;
            $display("FAIL decode step %0d: got cs=%0d ee=%b psr=%b, want cs=%0d ee=%b psr=%b",
                     i, cs, ee, psr, e.cs, e.ee, e.psr);
         end
      end
   endtask

   task automatic test_branch_flags();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      sq.push_back(st(1,0,0,0,0,0,0,0,0));        eq.push_back(ex(0,0,0));
      sq.push_back(idle());                       eq.push_back(ex(0,1,0));
      sq.push_back(st(0,6,1094,0,0,0,0,1,4'h4));  eq.push_back(ex(1094,0,4'h4));
      sq.push_back(idle());                       eq.push_back(ex(1094,1,4'h4));
      sq.push_back(st(0,2,1604,0,0,0,0,0,0));     eq.push_back(ex(1604,0,4'h4));
      sq.push_back(idle());                       eq.push_back(ex(1604,1,4'h4));
      sq.push_back(st(0,6,1094,0,0,0,0,1,4'h0));  eq.push_back(ex(1094,0,4'h0));
      sq.push_back(idle());                       eq.push_back(ex(1094,1,4'h0));
      sq.push_back(st(0,2,1604,0,0,0,0,1,4'h4));  eq.push_back(ex(1095,0,4'h4));
      sq.push_back(idle());                       eq.push_back(ex(1095,1,4'h4));
      sq.push_back(st(0,2,1604,0,0,0,0,0,0));     eq.push_back(ex(1604,0,4'h4));
      sq.push_back(idle());                       eq.push_back(ex(1604,1,4'h4));
      sq.push_back(st(0,1,7,0,0,0,0,0,0));        eq.push_back(ex(1605,0,4'h4));
      sq.push_back(idle());                       eq.push_back(ex(1605,1,4'h4));
      sq.push_back(st(0,5,300,IR_BIT13,0,0,0,0,0)); eq.push_back(ex(300,0,4'h4));
      sq.push_back(idle());                       eq.push_back(ex(300,1,4'h4));
      sq.push_back(st(0,4,9,0,0,0,0,1,4'h1));     eq.push_back(ex(301,0,4'h1));
      sq.push_back(idle());                       eq.push_back(ex(301,1,4'h1));
      sq.push_back(st(0,4,9,0,0,0,0,0,0));        eq.push_back(ex(9,0,4'h1));
      sq.push_back(idle());                       eq.push_back(ex(9,1,4'h1));
      sq.push_back(st(0,3,50,0,0,0,0,0,0));       eq.push_back(ex(10,0,4'h1));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb.push_back(eq[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (cs !== e.cs || ee !== e.ee || psr !== e.psr) begin
            fails++;
            $display("FAIL branch step %0d: got cs=%0d ee=%b psr=%b, want cs=%0d ee=%b psr=%b",
                     i, cs, ee, psr, e.cs, e.ee, e.psr);
         end
      end
   endtask

   task automatic test_wrap();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      sq.push_back(st(1,0,0,0,0,0,0,0,0));    eq.push_back(ex(0,0,0));
      sq.push_back(idle());                   eq.push_back(ex(0,1,0));
      sq.push_back(st(0,6,2047,0,0,0,0,0,0)); eq.push_back(ex(2047,0,0));
      sq.push_back(idle());                   eq.push_back(ex(2047,1,0));
      sq.push_back(st(0,0,5,0,0,0,0,0,0));    eq.push_back(ex(0,0,0));
      sq.push_back(idle());                   eq.push_back(ex(0,1,0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb.push_back(eq[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (cs !== e.cs || ee !== e.ee || psr !== e.psr) begin
            fails++;
            $display("FAIL wrap step %0d: got cs=%0d ee=%b psr=%b, want cs=%0d ee=%b psr=%b",
                     i, cs, ee, psr, e.cs, e.ee, e.psr);
         end
      end
   endtask

   task automatic test_mem_wait();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      sq.push_back(st(1,0,0,0,0,0,0,0,0));       eq.push_back(ex(0,0,0));
      sq.push_back(idle());                      eq.push_back(ex(0,1,0));
      sq.push_back(st(0,6,40,0,1,0,0,1,4'hF));   eq.push_back(ex(0,0,0));
      sq.push_back(st(0,6,40,0,1,0,0,1,4'hF));   eq.push_back(ex(0,0,0));
      sq.push_back(st(0,6,40,0,1,0,0,1,4'hF));   eq.push_back(ex(0,0,0));
      sq.push_back(st(0,6,40,0,1,0,1,1,4'h8));   eq.push_back(ex(40,0,4'h8));
      sq.push_back(st(0,0,0,0,0,0,1,0,0));       eq.push_back(ex(40,1,4'h8));
      sq.push_back(st(0,0,0,0,0,1,1,0,0));       eq.push_back(ex(41,0,4'h8));
      sq.push_back(idle());                      eq.push_back(ex(41,1,4'h8));
      sq.push_back(st(0,0,0,0,0,0,1,0,0));       eq.push_back(ex(42,0,4'h8));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb.push_back(eq[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (cs !== e.cs || ee !== e.ee || psr !== e.psr) begin
            fails++;
            $display("FAIL memwait step %0d: got cs=%0d ee=%b psr=%b, want cs=%0d ee=%b psr=%b",
                     i, cs, ee, psr, e.cs, e.ee, e.psr);
         end
      end
   endtask

   task automatic test_reset_priority();
      stim_t sq[$];
      exp_t  eq[$];
      exp_t  e;
      sq.push_back(st(1,0,0,0,0,0,0,0,0));        eq.push_back(ex(0,0,0));
      sq.push_back(idle());                       eq.push_back(ex(0,1,0));
      sq.push_back(st(0,6,100,0,0,0,0,1,4'hF));   eq.push_back(ex(100,0,4'hF));
      sq.push_back(idle());                       eq.push_back(ex(100,1,4'hF));
      sq.push_back(st(0,7,0,IR_ADDCC,1,0,0,0,0)); eq.push_back(ex(100,0,4'hF));
      sq.push_back(st(1,7,0,IR_ADDCC,1,0,1,1,4'hA)); eq.push_back(ex(0,0,0));
      sq.push_back(idle());                       eq.push_back(ex(0,1,0));
      sq.push_back(idle());                       eq.push_back(ex(1,0,0));
      sq.push_back(idle());                       eq.push_back(ex(1,1,0));
      sq.push_back(st(1,7,0,IR_ADDCC,0,0,0,1,4'hF)); eq.push_back(ex(0,0,0));
      sq.push_back(idle());                       eq.push_back(ex(0,1,0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb.push_back(eq[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (cs !== e.cs || ee !== e.ee || psr !== e.psr) begin
            fails++;
            $display("FAIL rstprio step %0d: got cs=%0d ee=%b psr=%b, want cs=%0d ee=%b psr=%b",
                     i, cs, ee, psr, e.cs, e.ee, e.psr);
         end
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      apply(st(1,0,0,0,0,0,0,0,0));
      test_reset();
      test_decode();
      test_branch_flags();
      test_wrap();
      test_mem_wait();
      test_reset_priority();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameters SHALL be declared as follows:
- DATAWIDTH_JUMPADDRESS, default 11: control-store address width.
- DATAWIDTH_CONDITION, default 3: MIR COND field width.
- DATAWIDTH_IR, default 32: instruction register width.
REQ-002 The clock SHALL be `MICROCODE_SEQUENCER_CLOCK_50`, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The reset SHALL be `MICROCODE_SEQUENCER_ResetInHigh_In`, input, 1 bit, synchronous and active-high.
REQ-004 The remaining ports SHALL be, in order:
- `MICROCODE_SEQUENCER_Condition_InBus`, in, 3: COND field of the current MIR.
- `MICROCODE_SEQUENCER_JumpAddress_InBus`, in, 11: JUMP ADDRESS field of the current MIR.
- `MICROCODE_SEQUENCER_IR_InBus`, in, 32: current instruction register.
- `MICROCODE_SEQUENCER_RD_In` / `MICROCODE_SEQUENCER_WRMain_In`, in, 1 each: MIR memory read/write request.
- `MICROCODE_SEQUENCER_MemAck_In`, in, 1: main memory completion.
- `MICROCODE_SEQUENCER_FlagsLoad_In`, in, 1: current ALU op sets condition codes.
- `MICROCODE_SEQUENCER_NZVC_InBus`, in, 4: ALU flags {N,Z,V,C}.
- `MICROCODE_SEQUENCER_CSAddress_OutBus`, out, 11: address to the microcode store.
- `MICROCODE_SEQUENCER_ExecEnable_Out`, out, 1: MIR valid this cycle; datapath may commit.
- `MICROCODE_SEQUENCER_PSR_OutBus`, out, 4: latched {n,z,v,c}.

Function
REQ-005 The block SHALL implement a three-state FSM:
- FETCH: the address is presented and the store loads the MIR on this edge.
- EXEC: MIR fields are valid.
- WAIT_MEM: a memory access is pending.
REQ-006 FETCH SHALL always go to EXEC after one cycle; ExecEnable SHALL be 0 in FETCH.
REQ-007 In EXEC, ExecEnable SHALL be 1.
- If (RD or WRMain) = 1 and MemAck = 0: go to WAIT_MEM and hold CSAddress.
- Otherwise: load CSAddress with the next address and go to FETCH.
REQ-008 In WAIT_MEM, ExecEnable SHALL be 0 and CSAddress SHALL hold; on MemAck = 1, load the next address and go to FETCH.
REQ-009 The next address SHALL be computed from the COND field:
- 000: CSAddress+1.
- 001: JumpAddress if n, else +1.
- 010: JumpAddress if z, else +1.
- 011: JumpAddress if v, else +1.
- 100: JumpAddress if c, else +1.
- 101: JumpAddress if IR[13], else +1.
- 110: JumpAddress unconditionally.
- 111: DECODE.
REQ-010 The DECODE address SHALL be {1'b1, IR[31:30], IR[24:19], 2'b00}.
- Example: addcc (op=10, op3=010000) decodes to 1600.
- Example: branch (op=00, IR[24:19]=010000) decodes to 1088.
REQ-011 The increment SHALL be modulo 2^11: 2047 wraps to 0, with no error flag.
REQ-012 The JumpAddress input SHALL be ignored for COND 000 and 111.
REQ-013 The PSR SHALL load NZVC_InBus only on the EXEC or WAIT_MEM exit edge when FlagsLoad = 1; otherwise it holds.
REQ-014 Condition tests SHALL use the PSR value before that same-edge update, so a flag set by the current microinstruction is visible to the next one only.
REQ-015 A MemAck received in FETCH, or in EXEC with no request, SHALL be ignored.
REQ-016 ExecEnable and CSAddress SHALL be registered outputs; the next-address logic SHALL be combinational from the registered state and the MIR fields.

Reset
REQ-017 While reset = 1 at a rising edge, the block SHALL set CSAddress=0, PSR=0000 and state=FETCH, with ExecEnable=0 in the following cycle.
REQ-018 Reset SHALL take priority over every other event, including MemAck in WAIT_MEM and a DECODE in EXEC.
REQ-019 Reset asserted mid-access SHALL abandon the pending access with no PSR update.
REQ-020 After reset release, the first EXEC cycle SHALL occur on the second clock (address 0 fetched first).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset held 2 cycles, then released with COND=000 at every EXEC -> CSAddress sequence 0,0,1,1,2; ExecEnable pattern 0,1,0,1.
- CSAddress=1, COND=111, IR[31:30]=10, IR[24:19]=010000 -> CSAddress=1600 after the EXEC edge.
- PSR z=1, COND=010, Jump=1604, CSAddress=1094 -> 1604; repeat with z=0 -> 1095.
- CSAddress=2047, COND=000 -> 0.
- EXEC with RD=1, MemAck low for 3 cycles, then high -> CSAddress held and ExecEnable=0 for those 3 cycles; advance on the ack edge.
- In WAIT_MEM, reset and MemAck asserted together -> CSAddress=0, PSR=0000, FETCH; FlagsLoad=1 in the same cycle is ignored.
